// File: rtl/pattern_misr_compactor.sv
// Pattern generator and response compactor for built-in self test.
// A Galois LFSR issues one stimulus pattern per cycle. A Galois MISR folds
// the in-order responses from the netlist under test into a signature.
// A run ends once the requested number of responses has been compacted.
module pattern_misr_compactor #(
  parameter int               PAT_W  = 22,
  parameter int               RSP_W  = 14,
  parameter int               CNT_W  = 16,
  parameter logic [PAT_W-1:0] POLY_P = 22'h300000,
  parameter logic [RSP_W-1:0] POLY_R = 14'h3802
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [PAT_W-1:0] seed,
  output logic [PAT_W-1:0] pat_o,
  output logic             pat_valid,
  input  logic [RSP_W-1:0] rsp_i,
  input  logic             rsp_valid,
  output logic             busy,
  output logic             done,
  output logic [RSP_W-1:0] signature
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] lfsr_q;
  logic [RSP_W-1:0] sig_q;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic [CNT_W-1:0] num_pat_q;
  logic [CNT_W-1:0] issued_inc;
  logic             done_q;
  logic             start_ok;
  logic             issue;
  logic             accept;
  logic             all_received;

  // A run may only be started while no run is in flight.
  assign start_ok     = start && ((state == IDLE) || (state == DONE));
  // Patterns are issued only while RUN still owes some; a zero-length run never issues.
  assign issue        = (state == RUN) && (issued_cnt != num_pat_q);
  // Responses count only inside a run and only up to the requested number.
  assign all_received = (recv_cnt == num_pat_q);
  assign accept       = ((state == RUN) || (state == DRAIN)) && rsp_valid && !all_received;
  assign issued_inc   = issued_cnt + 1'b1;

  // Next-state decode: RUN hands over to DRAIN with the last issued pattern,
  // and either busy state finishes the cycle after the last response lands.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (all_received) begin
          state_nxt = DONE;
        end else if (issue && (issued_inc == num_pat_q)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (all_received) state_nxt = DONE;
      end
      DONE: begin
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered done pulse, high for the single cycle after entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_nxt == DONE) && (state != DONE);
    end
  end

  // Datapath: a new run reloads everything, otherwise the LFSR and MISR step
  // independently; an all-zero seed would lock the LFSR so it becomes 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= '0;
      sig_q      <= '0;
      issued_cnt <= '0;
      recv_cnt   <= '0;
      num_pat_q  <= '0;
    end else if (start_ok) begin
      lfsr_q     <= (seed == '0) ? PAT_W'(1) : seed;
      sig_q      <= '0;
      issued_cnt <= '0;
      recv_cnt   <= '0;
      num_pat_q  <= num_pat;
    end else begin
      if (issue) begin
        lfsr_q     <= (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY_P : '0);
        issued_cnt <= issued_inc;
      end
      if (accept) begin
        sig_q    <= ((sig_q >> 1) ^ (sig_q[0] ? POLY_R : '0)) ^ rsp_i;
        recv_cnt <= recv_cnt + 1'b1;
      end
    end
  end

  assign pat_o     = lfsr_q;
  assign pat_valid = issue;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = done_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_pattern_misr_compactor.sv
// Self-checking bench for pattern_misr_compactor: a responder returns random
// responses with random in-order latency; expected patterns and signatures
// come from an arithmetic reference model of the LFSR and MISR rules.
module tb_pattern_misr_compactor;

  localparam int               PAT_W  = 22;
  localparam int               RSP_W  = 14;
  localparam int               CNT_W  = 16;
  localparam logic [PAT_W-1:0] POLY_P = 22'h300000;
  localparam logic [RSP_W-1:0] POLY_R = 14'h3802;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_pat = '0;
  logic [PAT_W-1:0] seed = '0;
  logic [PAT_W-1:0] pat_o;
  logic             pat_valid;
  logic [RSP_W-1:0] rsp_i = '0;
  logic             rsp_valid = 1'b0;
  logic             busy;
  logic             done;
  logic [RSP_W-1:0] signature;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Results of the most recent run, filled by drive_run.
  logic [PAT_W-1:0] got_pat[$];
  int               pat_cyc[$];
  logic [RSP_W-1:0] sent_rsp[$];
  logic [RSP_W-1:0] forced_rsp[$];
  int               done_cyc;
  bit               saw_drain;
  logic [RSP_W-1:0] final_sig;

  pattern_misr_compactor #(
    .PAT_W (PAT_W),
    .RSP_W (RSP_W),
    .CNT_W (CNT_W),
    .POLY_P(POLY_P),
    .POLY_R(POLY_R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_pat  (num_pat),
    .seed     (seed),
    .pat_o    (pat_o),
    .pat_valid(pat_valid),
    .rsp_i    (rsp_i),
    .rsp_valid(rsp_valid),
    .busy     (busy),
    .done     (done),
    .signature(signature)
  );

  always #5 clk = ~clk;

  // k-th pattern of a run: halve, and fold in the polynomial when the dropped bit was odd.
  function automatic logic [PAT_W-1:0] model_pat(input logic [PAT_W-1:0] s, input int k);
    longint unsigned v;
    v = (s == '0) ? 64'd1 : 64'(s);
    for (int i = 0; i < k; i++) begin
      if (v % 2 == 1) v = (v / 2) ^ 64'(POLY_P);
      else            v = v / 2;
    end
    return v[PAT_W-1:0];
  endfunction

  // Signature after compacting the first n responses that were sent.
  function automatic logic [RSP_W-1:0] model_sig(input int n);
    longint unsigned v;
    v = 0;
    for (int i = 0; i < n && i < sent_rsp.size(); i++) begin
      if (v % 2 == 1) v = (v / 2) ^ 64'(POLY_R);
      else            v = v / 2;
      v = v ^ 64'(sent_rsp[i]);
    end
    return v[RSP_W-1:0];
  endfunction

  // Start a run at the current negedge and act as the netlist under test until
  // done or the cycle budget expires. lat < 0 picks a random latency 0..3.
  task automatic drive_run(input logic [PAT_W-1:0] s, input int n, input int lat,
                           input bit mid_start);
    int due_q[$];
    logic [RSP_W-1:0] val_q[$];
    int last_due;
    int d;
    int budget;
    got_pat.delete();
    pat_cyc.delete();
    sent_rsp.delete();
    done_cyc  = -1;
    saw_drain = 1'b0;
    final_sig = '0;
    last_due  = 0;
    budget    = n * 8 + 60;
    start     = 1'b1;
    seed      = s;
    num_pat   = CNT_W'(n);
    rsp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (pat_valid) begin
        got_pat.push_back(pat_o);
        pat_cyc.push_back(cyc);
        d = cyc + ((lat >= 0) ? lat : int'($urandom_range(0, 3)));
        if (d < last_due) d = last_due;
        last_due = d;
        due_q.push_back(d);
        if (forced_rsp.size() > 0) val_q.push_back(forced_rsp.pop_front());
        else                       val_q.push_back(RSP_W'($urandom));
      end
      if (busy && !pat_valid && got_pat.size() > 0) saw_drain = 1'b1;
      if (done) begin
        done_cyc  = cyc;
        final_sig = signature;
        rsp_valid = 1'b0;
        start     = 1'b0;
        break;
      end
      rsp_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        rsp_valid = 1'b1;
        rsp_i     = val_q.pop_front();
        void'(due_q.pop_front());
        sent_rsp.push_back(rsp_i);
      end
      start = mid_start && (cyc == 2);
      if (start) begin
        seed    = ~s;
        num_pat = CNT_W'(n + 3);
      end
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    check_cnt++;
    if (pat_o !== '0) $display("[TB] FAIL reset_pat_o: got %h expected 0", pat_o);
    else pass_cnt++;
    check_cnt++;
    if (pat_valid !== 1'b0) $display("[TB] FAIL reset_pat_valid: got %b expected 0", pat_valid);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    check_cnt++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
    else pass_cnt++;
    check_cnt++;
    if (signature !== '0) $display("[TB] FAIL reset_signature: got %h expected 0", signature);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++;
    if (busy !== 1'b0 || pat_valid !== 1'b0)
      $display("[TB] FAIL idle_after_release: got busy=%b pat_valid=%b expected 0/0", busy, pat_valid);
    else pass_cnt++;
  endtask

  task automatic test_zero_patterns;
    drive_run(22'h12345, 0, 0, 1'b0);
    check_cnt++;
    if (done_cyc != 1) $display("[TB] FAIL zero_done_timing: got cycle %0d expected 1", done_cyc);
    else pass_cnt++;
    check_cnt++;
    if (got_pat.size() != 0) $display("[TB] FAIL zero_pat_valid: got %0d patterns expected 0", got_pat.size());
    else pass_cnt++;
    check_cnt++;
    if (final_sig !== '0) $display("[TB] FAIL zero_signature: got %h expected 0", final_sig);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done !== 1'b0) $display("[TB] FAIL zero_done_pulse: got %b expected 0", done);
    else pass_cnt++;
  endtask

  task automatic test_seed_one;
    forced_rsp.delete();
    forced_rsp.push_back(14'h0001);
    forced_rsp.push_back(14'h0000);
    drive_run(22'h000001, 2, 0, 1'b0);
    check_cnt++;
    if (done_cyc < 0) $display("[TB] FAIL seed1_completed: got timeout expected done");
    else pass_cnt++;
    check_cnt++;
    if (got_pat.size() != 2) $display("[TB] FAIL seed1_count: got %0d expected 2", got_pat.size());
    else pass_cnt++;
    if (got_pat.size() == 2) begin
      check_cnt++;
      if (got_pat[0] !== 22'h000001) $display("[TB] FAIL seed1_pat0: got %h expected 000001", got_pat[0]);
      else pass_cnt++;
      check_cnt++;
      if (got_pat[1] !== 22'h300000) $display("[TB] FAIL seed1_pat1: got %h expected 300000", got_pat[1]);
      else pass_cnt++;
      check_cnt++;
      if (pat_cyc[1] != pat_cyc[0] + 1)
        $display("[TB] FAIL seed1_consecutive: got cycles %0d,%0d expected adjacent", pat_cyc[0], pat_cyc[1]);
      else pass_cnt++;
    end
    check_cnt++;
    if (!saw_drain) $display("[TB] FAIL seed1_drain: got no drain cycle expected one");
    else pass_cnt++;
    check_cnt++;
    if (final_sig !== 14'h3802) $display("[TB] FAIL seed1_signature: got %h expected 3802", final_sig);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done !== 1'b0 || signature !== 14'h3802)
      $display("[TB] FAIL seed1_hold: got done=%b sig=%h expected 0/3802", done, signature);
    else pass_cnt++;
  endtask

  task automatic test_late_response;
    forced_rsp.delete();
    forced_rsp.push_back(14'h0005);
    drive_run(RSP_W'(0) == 0 ? 22'h0abcde : 22'h0, 1, 10, 1'b0);
    check_cnt++;
    if (done_cyc < 0) $display("[TB] FAIL late_completed: got timeout expected done");
    else pass_cnt++;
    check_cnt++;
    if (final_sig !== 14'h0005) $display("[TB] FAIL late_signature: got %h expected 0005", final_sig);
    else pass_cnt++;
    rsp_valid = 1'b1;
    rsp_i     = 14'h1fff;
    @(negedge clk);
    rsp_valid = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (signature !== 14'h0005) $display("[TB] FAIL late_extra_ignored: got %h expected 0005", signature);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL late_stays_done: got busy=%b done=%b expected 0/0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    logic [PAT_W-1:0] s;
    s = PAT_W'($urandom) | 22'h1;
    drive_run(s, 8, -1, 1'b1);
    check_cnt++;
    if (got_pat.size() != 8) $display("[TB] FAIL busy_start_count: got %0d expected 8", got_pat.size());
    else pass_cnt++;
    for (int i = 0; i < got_pat.size() && i < 8; i++) begin
      check_cnt++;
      if (got_pat[i] !== model_pat(s, i))
        $display("[TB] FAIL busy_start_pat%0d: got %h expected %h", i, got_pat[i], model_pat(s, i));
      else pass_cnt++;
    end
    check_cnt++;
    if (done_cyc < 0 || final_sig !== model_sig(8))
      $display("[TB] FAIL busy_start_sig: got %h expected %h", final_sig, model_sig(8));
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random_runs;
    logic [PAT_W-1:0] s;
    int n;
    int bad;
    for (int r = 0; r < 6; r++) begin
      s = (r == 0) ? '0 : PAT_W'($urandom);
      n = int'($urandom_range(1, 12));
      drive_run(s, n, -1, 1'b0);
      bad = 0;
      for (int i = 0; i < got_pat.size(); i++)
        if (got_pat[i] !== model_pat(s, i)) bad++;
      check_cnt++;
      if (got_pat.size() != n || bad != 0)
        $display("[TB] FAIL rand%0d_patterns: got %0d patterns (%0d wrong) expected %0d", r, got_pat.size(), bad, n);
      else pass_cnt++;
      check_cnt++;
      if (done_cyc < 0 || final_sig !== model_sig(n))
        $display("[TB] FAIL rand%0d_signature: got %h expected %h", r, final_sig, model_sig(n));
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [PAT_W-1:0] s;
    s = PAT_W'($urandom);
    drive_run(PAT_W'($urandom), 3, -1, 1'b0);
    drive_run(s, 5, -1, 1'b0);
    check_cnt++;
    if (got_pat.size() != 5 || got_pat[0] !== model_pat(s, 0))
      $display("[TB] FAIL b2b_patterns: got %0d patterns expected 5 starting %h", got_pat.size(), model_pat(s, 0));
    else pass_cnt++;
    check_cnt++;
    if (done_cyc < 0 || final_sig !== model_sig(5))
      $display("[TB] FAIL b2b_signature: got %h expected %h", final_sig, model_sig(5));
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic [PAT_W-1:0] s;
    s = PAT_W'($urandom) | 22'h2;
    start   = 1'b1;
    seed    = s;
    num_pat = CNT_W'(20);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      rsp_valid = 1'b1;
      rsp_i     = RSP_W'($urandom);
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    check_cnt++;
    if (busy !== 1'b1) $display("[TB] FAIL midrst_running: got busy=%b expected 1", busy);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if (pat_o !== '0 || pat_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || signature !== '0)
      $display("[TB] FAIL midrst_outputs: got pat=%h pv=%b busy=%b done=%b sig=%h expected all 0",
               pat_o, pat_valid, busy, done, signature);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_cnt++;
      if (busy !== 1'b0 || pat_valid !== 1'b0 || done !== 1'b0 || signature !== '0)
        $display("[TB] FAIL midrst_idle: got busy=%b pv=%b done=%b sig=%h expected 0", busy, pat_valid, done, signature);
      else pass_cnt++;
    end
    drive_run(s, 6, -1, 1'b0);
    check_cnt++;
    if (got_pat.size() != 6 || got_pat[0] !== model_pat(s, 0))
      $display("[TB] FAIL midrst_fresh_patterns: got %0d patterns expected 6", got_pat.size());
    else pass_cnt++;
    check_cnt++;
    if (done_cyc < 0 || final_sig !== model_sig(6))
      $display("[TB] FAIL midrst_fresh_sig: got %h expected %h", final_sig, model_sig(6));
    else pass_cnt++;
    @(negedge clk);
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_zero_patterns();
    test_seed_one();
    test_late_response();
    test_start_ignored();
    test_random_runs();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
